// File: rtl/uart_tx.sv
// AXI4-Stream to UART serialiser: one word per handshake becomes a start bit,
// LSB-first data, optional parity and one or two stop bits on txd.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  busy,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  two_stop,
    input  logic [15:0]           prescale
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [18:0]           cnt_q, cnt_d;
    logic [18:0]           period_q, period_d;
    logic [3:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  par_en_q, par_en_d;
    logic                  two_stop_q, two_stop_d;
    logic                  stop2_q, stop2_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
    logic                  tready_q, tready_d;

    logic                  period_end;
    logic [15:0]           p_eff;

    assign period_end = (cnt_q == 19'd0);
    assign p_eff      = (prescale == 16'd0) ? 16'd1 : prescale;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        stop2_d    = stop2_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        tready_d   = tready_q;

        // Every non-idle state counts down its bit period; the case below reloads on expiry.
        if (state_q != ST_IDLE && !period_end) begin
            cnt_d = cnt_q - 19'd1;
        end

        case (state_q)
            ST_IDLE: begin
                txd_d    = 1'b1;
                busy_d   = 1'b0;
                tready_d = 1'b1;
                if (s_axis_tvalid && tready_q) begin
                    shreg_d    = s_axis_tdata;
                    par_d      = (^s_axis_tdata) ^ parity_odd;
                    par_en_d   = parity_en;
                    two_stop_d = two_stop;
                    period_d   = {p_eff, 3'b000} - 19'd1;
                    cnt_d      = {p_eff, 3'b000} - 19'd1;
                    tready_d   = 1'b0;
                    busy_d     = 1'b1;
                    txd_d      = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (period_end) begin
                    txd_d   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    bit_d   = 4'(DATA_WIDTH - 1);
                    cnt_d   = period_q;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (period_end) begin
                    cnt_d = period_q;
                    if (bit_q != 4'd0) begin
                        txd_d   = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q - 4'd1;
                    end else if (par_en_q) begin
                        txd_d   = par_q;
                        state_d = ST_PARITY;
                    end else begin
                        txd_d   = 1'b1;
                        stop2_d = two_stop_q;
                        state_d = ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (period_end) begin
                    txd_d   = 1'b1;
                    stop2_d = two_stop_q;
                    cnt_d   = period_q;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (period_end) begin
                    if (stop2_q) begin
                        stop2_d = 1'b0;
                        cnt_d   = period_q;
                    end else begin
                        tready_d = 1'b1;
                        busy_d   = 1'b0;
                        txd_d    = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            tready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            stop2_q    <= stop2_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            tready_q   <= tready_d;
        end
    end

    assign txd           = txd_q;
    assign busy          = busy_q;
    assign s_axis_tready = tready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of single frames plus hand-written
// back-to-back, mid-frame reset and mid-frame config-change sequences.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_axis_tdata = 8'h00;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        txd;
    logic        busy;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        two_stop = 1'b0;
    logic [15:0] prescale = 16'd1;

    int tests = 0;
    int fails = 0;
    int hs_cnt = 0;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .txd           (txd),
        .busy          (busy),
        .parity_en     (parity_en),
        .parity_odd    (parity_odd),
        .two_stop      (two_stop),
        .prescale      (prescale)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_axis_tvalid && s_axis_tready) hs_cnt <= hs_cnt + 1;
    end

    // Frame bits are listed in transmit order, left-justified in 12 bits.
    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        po;
        logic        ts;
        logic [15:0] ps;
        int          p_eff;
        int          nbits;
        logic [11:0] bits;
    } vec_t;

    vec_t vecs[5];

    task automatic chk3(input string nm, input logic [2:0] act, input logic [2:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: {txd,busy,tready}=%b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Returns just after the accepting edge.
    task automatic start_frame(input logic [7:0] d, input logic pe, input logic po,
                               input logic ts, input logic [15:0] ps, input bit keep);
        int k;
        k = 0;
        @(negedge clk);
        while (!s_axis_tready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!s_axis_tready) begin
            fails++;
            $display("FAIL handshake_wait: tready=%b expected 1 within 2000 clk", s_axis_tready);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1, "tready timeout");
        end
        s_axis_tdata  = d;
        parity_en     = pe;
        parity_odd    = po;
        two_stop      = ts;
        prescale      = ps;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) s_axis_tvalid = 1'b0;
    endtask

    task automatic check_frame(input string nm, input logic [11:0] bits, input int n, input int p);
        for (int c = 0; c < 8 * p * n; c++) begin
            @(negedge clk);
            chk3(nm, {txd, busy, s_axis_tready}, {bits[11 - c / (8 * p)], 1'b1, 1'b0});
        end
        @(negedge clk);
        chk3({nm, "_end"}, {txd, busy, s_axis_tready}, 3'b101);
    endtask

    initial begin
        int hs0;
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 16'd1, 1, 10, 12'b0101_0010_1100};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 16'd1, 1, 11, 12'b0111_0000_0110};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 16'd1, 1, 11, 12'b0111_0000_0010};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 16'd0, 1, 11, 12'b0000_0000_0110};
        vecs[4] = '{8'h81, 1'b1, 1'b1, 1'b1, 16'd1, 1, 12, 12'b0100_0000_1111};

        repeat (3) @(negedge clk);
        chk3("reset_state", {txd, busy, s_axis_tready}, 3'b100);
        rst = 1'b0;
        #1;
        chk3("reset_release", {txd, busy, s_axis_tready}, 3'b100);
        @(negedge clk);
        chk3("first_edge_ready", {txd, busy, s_axis_tready}, 3'b101);

        for (int i = 0; i < 5; i++) begin
            start_frame(vecs[i].data, vecs[i].pe, vecs[i].po, vecs[i].ts, vecs[i].ps, 1'b0);
            check_frame($sformatf("vec%0d", i), vecs[i].bits, vecs[i].nbits, vecs[i].p_eff);
        end

        // Back-to-back with tvalid held: one idle-high clock between frames.
        hs0 = hs_cnt;
        start_frame(8'h55, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1);
        s_axis_tdata = 8'hAA;
        check_frame("b2b_55", 12'b0101_0101_0100, 10, 2);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        check_frame("b2b_AA", 12'b0010_1010_1100, 10, 2);
        repeat (4) @(negedge clk);
        chk_int("b2b_handshakes", hs_cnt - hs0, 2);

        // Reset during data bit 3 (a low bit of 0xA5).
        start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0);
        repeat (36) @(negedge clk);
        chk3("pre_reset_bit3", {txd, busy, s_axis_tready}, 3'b010);
        rst = 1'b1;
        #1;
        chk3("async_reset", {txd, busy, s_axis_tready}, 3'b100);
        @(negedge clk);
        chk3("held_reset", {txd, busy, s_axis_tready}, 3'b100);
        rst = 1'b0;
        #1;
        chk3("reset_release2", {txd, busy, s_axis_tready}, 3'b100);
        @(negedge clk);
        chk3("ready_after_reset", {txd, busy, s_axis_tready}, 3'b101);
        start_frame(8'h3C, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0);
        check_frame("after_reset_3C", 12'b0001_1110_0100, 10, 1);

        // Config and data changes while busy must not affect the current frame.
        start_frame(8'h5A, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0);
        prescale     = 16'd4;
        two_stop     = 1'b1;
        parity_en    = 1'b1;
        s_axis_tdata = 8'hFF;
        check_frame("cfg_old_5A", 12'b0010_1101_0100, 10, 1);
        start_frame(8'hF0, 1'b0, 1'b0, 1'b1, 16'd4, 1'b0);
        check_frame("cfg_new_F0", 12'b0000_0111_1110, 11, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- AXI4-Stream to UART serialiser: accepts one DATA_WIDTH word per handshake and drives an asynchronous serial frame on txd.
- Frame format: start bit, data LSB first, optional parity bit, 1 or 2 stop bits.
- Transmit-side peer of the UART receiver; uses the same prescale convention (bit period = prescale*8 clk).
- Sits between the UART wrapper/host FIFO and the FPGA TX pin.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9 supported)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
s_axis_tdata  input  DATA_WIDTH  word to transmit
s_axis_tvalid  input  1  tdata valid
s_axis_tready  output  1  block can accept a word (registered)
txd  output  1  serial output, idle high (registered)
busy  output  1  frame in progress (registered)
parity_en  input  1  1 = append parity bit
parity_odd  input  1  0 = even parity, 1 = odd parity
two_stop  input  1  1 = two stop bits, 0 = one stop bit
prescale  input  16  clocks per bit divided by 8

Behaviour:
- Reset (async assert, sync release):
  - txd=1, s_axis_tready=0, busy=0; FSM to IDLE; counters and shift register cleared.
  - s_axis_tready rises on the first clk edge after rst deasserts.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - txd=1, busy=0, s_axis_tready=1.
  - On an edge with s_axis_tvalid && s_axis_tready:
    - latch tdata, parity_en, parity_odd, two_stop and prescale;
    - s_axis_tready<=0, busy<=1, txd<=0; go to START.
- Bit timing:
  - Each bit is held on txd for exactly 8*P clocks, where P = latched prescale.
  - P=0 is treated as P=1 (8 clocks per bit).
  - Prescale counter is 19 bits; loaded with 8*P-1 and decremented to 0.
- START: after the period, drive data bit 0; go to DATA.
- DATA:
  - Shift out bits LSB first; bit counter counts DATA_WIDTH bits.
  - After the last data bit, go to PARITY if parity_en is latched, else STOP.
- PARITY:
  - txd = XOR of latched data (even), or its inverse (odd).
  - After one period, go to STOP.
- STOP:
  - txd=1 for 1 or 2 periods according to latched two_stop.
  - On the edge ending the final stop period: s_axis_tready<=1, busy<=0, go to IDLE.
- Latency and spacing:
  - txd falls on the same edge as the accepting handshake.
  - Frame length N = 1 + DATA_WIDTH + parity_en + (two_stop ? 2 : 1) bits; busy stays high for exactly 8*P*N clocks.
  - Back-to-back: with tvalid held high, the next start bit begins exactly 1 clk after the final stop period ends (one idle-high clock between frames).
- Config and data stability:
  - parity_en, parity_odd, two_stop and prescale changes while busy=1 do not affect the current frame.
  - Changes to s_axis_tdata while tready=0 are ignored.
- No handshake is ever accepted while busy=1.
- Asserting rst mid-frame forces txd=1 immediately with no clock edge; the partial frame is abandoned and not resent.

Test Plan:
- prescale=1, DATA_WIDTH=8, no parity, 1 stop, send 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each level held 8 clk; busy high 80 clk; tready low for the same 80 clk.
- parity_en=1, parity_odd=0, send 0x07 -> parity bit = 1; repeat with parity_odd=1 -> parity bit = 0; frame = 11 bits = 88 clk at prescale=1.
- two_stop=1, prescale=0, send 0x00 -> 8 clk per bit; stop high for 16 clk; busy high 88 clk.
- tvalid held high with words 0x55 then 0xAA, prescale=2 -> second start bit falls exactly 1 clk after the first frame's 16-clk stop bit ends; exactly two handshakes occur.
- rst pulsed during DATA bit 3 -> txd=1 immediately (no clock edge); busy=0, tready=0 during reset; tready=1 one edge after release; the next 0x3C frame is correct.
- Toggle prescale 1->4 and two_stop 0->1 mid-frame -> current frame keeps 8-clk bits and 1 stop bit; the next frame uses 32-clk bits and 2 stop bits.
